// File: rtl/pulse_gen_monitor.sv
// Pulse train checker: measures high/low widths of a synchronized
// input and flags width violations and pulses seen while disabled.
module pulse_gen_monitor #(
    parameter int CNT_W       = 16,
    parameter int EXP_HIGH    = 100,
    parameter int EXP_LOW     = 100,
    parameter int TOL         = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] high_cycles,
    output logic [CNT_W-1:0] low_cycles,
    output logic             meas_valid,
    output logic             width_err,
    output logic             err_sticky,
    output logic             enable_err,
    output logic [15:0]      period_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic signed [CNT_W:0] EXP_H_S = (CNT_W+1)'(EXP_HIGH);
    localparam logic signed [CNT_W:0] EXP_L_S = (CNT_W+1)'(EXP_LOW);
    localparam logic signed [CNT_W:0] TOL_S   = (CNT_W+1)'(TOL);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] en_q;
    logic                   prev_q;
    logic                   ps;
    logic                   en_d;
    logic                   rise;
    logic                   fall;
    logic                   en_viol;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] hi_q;
    logic [CNT_W-1:0] hi_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             report;

    logic signed [CNT_W:0] d_hi;
    logic signed [CNT_W:0] d_lo;
    logic                  err_hi;
    logic                  err_lo;
    logic                  werr;

    assign ps      = sync_q[SYNC_STAGES-1];
    assign en_d    = en_q[SYNC_STAGES-1];
    assign rise    = ps & ~prev_q;
    assign fall    = ~ps & prev_q;
    assign en_viol = ~en_d & ps;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // Width checks, signed so short and long phases both trip.
    assign d_hi   = $signed({1'b0, hi_q}) - EXP_H_S;
    assign d_lo   = $signed({1'b0, cnt_q}) - EXP_L_S;
    assign err_hi = (hi_q == CNT_MAX) || (d_hi > TOL_S) || (d_hi < -TOL_S);
    assign err_lo = (cnt_q == CNT_MAX) || (d_lo > TOL_S) || (d_lo < -TOL_S);
    assign werr   = err_hi | err_lo;

    // Input synchronizer; enable is delayed alongside for the error check.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            en_q   <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= pulse_in;
            en_q[0]   <= enable;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
                en_q[i]   <= en_q[i-1];
            end
            prev_q <= ps;
        end
    end

    // Measurement FSM state and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
        end
    end

    // Next state: disable dominates; a period closes on the next rise.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        report  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_d = LOW;
                        hi_d    = cnt_q;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_ONE;
                        report  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Registered results and strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            high_cycles  <= '0;
            low_cycles   <= '0;
            meas_valid   <= 1'b0;
            width_err    <= 1'b0;
            err_sticky   <= 1'b0;
            enable_err   <= 1'b0;
            period_count <= '0;
        end else begin
            meas_valid <= report;
            width_err  <= report & werr;
            enable_err <= en_viol;
            err_sticky <= err_sticky | (report & werr) | en_viol;
            if (report) begin
                high_cycles  <= hi_q;
                low_cycles   <= cnt_q;
                period_count <= period_count + 16'd1;
            end
        end
    end

endmodule
